// File: rtl/oam_dma_if.sv
// CPU-side and system-side memory bus bundle for the sprite DMA controller.
// master is the controller's view; slave is the CPU/memory side.
interface oam_dma_if;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data_out;
    logic        cpu_write_en;
    logic        cpu_read_en;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data_out;
    logic        mem_write_en;
    logic        mem_read_en;
    logic [7:0]  mem_data_in;

    modport master (
        input  cpu_addr, cpu_data_out, cpu_write_en, cpu_read_en, mem_data_in,
        output mem_addr, mem_data_out, mem_write_en, mem_read_en
    );

    modport slave (
        output cpu_addr, cpu_data_out, cpu_write_en, cpu_read_en, mem_data_in,
        input  mem_addr, mem_data_out, mem_write_en, mem_read_en
    );
endinterface

// File: rtl/oam_dma_ctrl.sv
// Sprite DMA engine: passes the CPU bus through when idle; a write to the trigger address
// halts the CPU and copies one page of memory to the OAM data port.
module oam_dma_ctrl #(
    parameter logic [15:0] DMA_TRIG_ADDR = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
    parameter int unsigned XFER_LEN      = 256
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      soft_rst,
    oam_dma_if.master bus,
    output logic      cpu_halt,
    output logic      dma_busy
);
    typedef enum logic [2:0] {StIdle, StDummy, StAlign, StRead, StWrite} state_e;

    localparam logic [7:0] LastIdx = 8'(XFER_LEN - 1);

    state_e      state_q, state_d;
    logic [7:0]  page_q, page_d;
    logic [7:0]  idx_q, idx_d;
    logic        par_q;
    logic        halt_q;
    logic        trigger;
    logic [15:0] addr_c;
    logic [7:0]  data_c;
    logic        we_c, re_c;

    assign trigger = bus.cpu_write_en && (bus.cpu_addr == DMA_TRIG_ADDR);

    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        idx_d   = idx_q;
        addr_c  = 16'h0000;
        data_c  = 8'h00;
        we_c    = 1'b0;
        re_c    = 1'b0;
        unique case (state_q)
            StIdle: begin
                addr_c = bus.cpu_addr;
                data_c = bus.cpu_data_out;
                re_c   = bus.cpu_read_en;
                // The trigger write is consumed here, never forwarded to the system bus.
                we_c   = bus.cpu_write_en && !trigger;
                if (trigger && !soft_rst) begin
                    page_d  = bus.cpu_data_out;
                    idx_d   = 8'h00;
                    state_d = StDummy;
                end
            end
            StDummy: state_d = par_q ? StAlign : StRead;
            StAlign: state_d = StRead;
            StRead: begin
                addr_c  = {page_q, idx_q};
                re_c    = 1'b1;
                state_d = StWrite;
            end
            StWrite: begin
                addr_c = OAM_DATA_ADDR;
                data_c = bus.mem_data_in;
                we_c   = 1'b1;
                if (idx_q == LastIdx) begin
                    state_d = StIdle;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = StRead;
                end
            end
            default: state_d = StIdle;
        endcase
        if (soft_rst) state_d = StIdle;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            page_q  <= 8'h00;
            idx_q   <= 8'h00;
            par_q   <= 1'b0;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            page_q  <= page_d;
            idx_q   <= idx_d;
            par_q   <= ~par_q;
            halt_q  <= (state_d != StIdle);
        end
    end

    assign bus.mem_addr     = addr_c;
    assign bus.mem_data_out = data_c;
    assign bus.mem_write_en = we_c;
    assign bus.mem_read_en  = re_c;
    assign cpu_halt         = halt_q;
    assign dma_busy         = halt_q;
endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Bench for oam_dma_ctrl: passthrough vector table, directed transfer corner cases and
// random traffic checked against a per-cycle expected-bus schedule model.
module tb_oam_dma_ctrl;
    logic clk, rst, soft_rst;
    logic cpu_halt, dma_busy;
    oam_dma_if bus();

    oam_dma_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .soft_rst (soft_rst),
        .bus      (bus),
        .cpu_halt (cpu_halt),
        .dma_busy (dma_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory responds one cycle after a read strobe; content is addr[7:0]^A5.
    always @(posedge clk) begin
        if (bus.mem_read_en) bus.mem_data_in <= bus.mem_addr[7:0] ^ 8'hA5;
    end

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
        logic        we;
        logic        re;
        logic        halt;
    } exp_t;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
        logic        we;
        logic        re;
        logic [15:0] ea;
        logic [7:0]  ed;
        logic        ewe;
        logic        ere;
    } vec_t;

    exp_t exp_q[$];
    logic mpar;
    int   checks = 0, errors = 0;
    int   halt_seen = 0, zero_hits = 0, oam_writes = 0;

    // Whole transfer laid out as one expected bus record per cycle.
    task automatic build(input logic [7:0] page, input logic dummy_par);
        exp_t e;
        e = '{addr: 16'h0000, data: 8'h00, we: 1'b0, re: 1'b0, halt: 1'b1};
        exp_q.push_back(e);
        if (dummy_par) exp_q.push_back(e);
        for (int i = 0; i < 256; i++) begin
            e = '{addr: {page, 8'(i)}, data: 8'h00, we: 1'b0, re: 1'b1, halt: 1'b1};
            exp_q.push_back(e);
            e = '{addr: 16'h2004, data: 8'(i) ^ 8'hA5, we: 1'b1, re: 1'b0, halt: 1'b1};
            exp_q.push_back(e);
        end
    endtask

    function automatic logic [27:0] model_out();
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q[0];
        end else begin
            e.addr = bus.cpu_addr;
            e.data = bus.cpu_data_out;
            e.we   = bus.cpu_write_en && (bus.cpu_addr != 16'h4014);
            e.re   = bus.cpu_read_en;
            e.halt = 1'b0;
        end
        return {e.addr, e.data, e.we, e.re, e.halt, e.halt};
    endfunction

    task automatic advance();
        logic trig;
        trig = bus.cpu_write_en && (bus.cpu_addr == 16'h4014);
        if (rst) begin
            exp_q.delete();
            mpar = 1'b0;
        end else begin
            if (soft_rst) exp_q.delete();
            else if (exp_q.size() > 0) void'(exp_q.pop_front());
            else if (trig) build(bus.cpu_data_out, ~mpar);
            mpar = ~mpar;
        end
    endtask

    task automatic check(input string name, input logic [27:0] req);
        logic [27:0] act;
        act = {bus.mem_addr, bus.mem_data_out, bus.mem_write_en, bus.mem_read_en,
               cpu_halt, dma_busy};
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, req);
        end
        if (cpu_halt) halt_seen++;
        if ((bus.mem_write_en || bus.mem_read_en) && bus.mem_addr == 16'h0000) zero_hits++;
        if (bus.mem_write_en && bus.mem_addr == 16'h2004) oam_writes++;
    endtask

    task automatic chk_int(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic drive(input logic [15:0] a, input logic [7:0] d, input logic we,
                         input logic re, input logic sr, input logic r);
        bus.cpu_addr     = a;
        bus.cpu_data_out = d;
        bus.cpu_write_en = we;
        bus.cpu_read_en  = re;
        soft_rst         = sr;
        rst              = r;
    endtask

    task automatic step(input string name, input logic [15:0] a, input logic [7:0] d,
                        input logic we, input logic re, input logic sr, input logic r);
        drive(a, d, we, re, sr, r);
        #3;
        check(name, model_out());
        advance();
        @(posedge clk);
        #1;
    endtask

    // Random CPU traffic that can never hit the trigger address or $0000.
    task automatic noise_steps(input string name, input int n);
        logic we;
        for (int k = 0; k < n; k++) begin
            we = 1'($urandom);
            step(name, 16'h0100 + 16'($urandom_range(0, 16'h3E00)), 8'($urandom), we,
                 ~we & 1'($urandom), 1'b0, 1'b0);
        end
    endtask

    task automatic idle_until_par(input logic p);
        for (int k = 0; k < 2 && mpar != p; k++) step("idle", 16'h1000, 8'h00, 0, 0, 0, 0);
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{16'h0300, 8'h5A, 1, 0, 16'h0300, 8'h5A, 1, 0};
        vecs[1] = '{16'h2002, 8'h33, 0, 1, 16'h2002, 8'h33, 0, 1};
        vecs[2] = '{16'h4014, 8'h77, 0, 1, 16'h4014, 8'h77, 0, 1};
        vecs[3] = '{16'h4015, 8'h12, 1, 0, 16'h4015, 8'h12, 1, 0};
        vecs[4] = '{16'hFFFF, 8'hC3, 0, 0, 16'hFFFF, 8'hC3, 0, 0};
        vecs[5] = '{16'h4013, 8'h01, 1, 0, 16'h4013, 8'h01, 1, 0};

        drive(16'h0000, 8'h00, 0, 0, 0, 1);
        @(posedge clk);
        #1;
        exp_q.delete();
        mpar = 1'b0;
        step("reset_state", 16'h0000, 8'h00, 0, 0, 0, 0);

        for (int i = 0; i < 6; i++) begin
            drive(vecs[i].a, vecs[i].d, vecs[i].we, vecs[i].re, 1'b0, 1'b0);
            #3;
            check($sformatf("vec%0d", i), {vecs[i].ea, vecs[i].ed, vecs[i].ewe, vecs[i].ere,
                                          2'b00});
            advance();
            @(posedge clk);
            #1;
        end
        step("no_busy_after_vec", 16'h0000, 8'h00, 0, 0, 0, 0);

        // DUMMY parity 0: trigger issued while par is 1.
        idle_until_par(1'b1);
        halt_seen = 0;
        step("trig_even", 16'h4014, 8'h02, 1, 0, 0, 0);
        noise_steps("xfer_even", 520);
        chk_int("halt_len_even", halt_seen, 513);

        idle_until_par(1'b0);
        halt_seen = 0;
        step("trig_odd", 16'h4014, 8'h02, 1, 0, 0, 0);
        noise_steps("xfer_odd", 520);
        chk_int("halt_len_odd", halt_seen, 514);

        zero_hits = 0;
        oam_writes = 0;
        step("trig_ff", 16'h4014, 8'hFF, 1, 0, 0, 0);
        noise_steps("xfer_ff", 520);
        chk_int("page_ff_zero_access", zero_hits, 0);

        step("trig_soft", 16'h4014, 8'h05, 1, 0, 0, 0);
        for (int k = 0; k < 600; k++) begin
            if (exp_q.size() > 0 && exp_q[0].re && exp_q[0].addr == 16'h0564) break;
            step("to_idx100", 16'h1000, 8'h00, 0, 0, 0, 0);
        end
        chk_int("reached_idx100", int'(exp_q.size() > 0 && exp_q[0].addr == 16'h0564), 1);
        step("soft_at_read", 16'h1000, 8'h00, 0, 0, 1, 0);
        chk_int("halt_after_soft", int'(cpu_halt), 0);
        oam_writes = 0;
        noise_steps("after_soft", 10);
        chk_int("no_oam_after_soft", oam_writes, 0);

        halt_seen = 0;
        step("soft_with_trig", 16'h4014, 8'h09, 1, 0, 1, 0);
        noise_steps("after_soft_trig", 5);
        chk_int("soft_trig_no_halt", halt_seen, 0);

        step("trig_rst", 16'h4014, 8'h07, 1, 0, 0, 0);
        noise_steps("xfer_rst", 50);
        step("rst_mid", 16'h1000, 8'h00, 0, 0, 0, 1);
        step("rst_state", 16'h0000, 8'h00, 0, 0, 0, 0);
        step("rst_idle", 16'h0000, 8'h00, 0, 0, 0, 0);
        // Two cycles after reset par is 0 again, so DUMMY sees par 1 and ALIGN is inserted.
        halt_seen = 0;
        step("trig_after_rst", 16'h4014, 8'h01, 1, 0, 0, 0);
        noise_steps("xfer_after_rst", 520);
        chk_int("halt_len_after_rst", halt_seen, 514);

        for (int k = 0; k < 3000; k++) begin
            logic [15:0] a;
            logic        we;
            a  = ($urandom_range(0, 7) == 0) ? 16'h4014 : 16'($urandom);
            we = 1'($urandom);
            step("rand", a, 8'($urandom), we, ~we & 1'($urandom),
                 $urandom_range(0, 399) == 0, $urandom_range(0, 1499) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
